// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS front end: fetch state encoding,
// reset PC, instruction memory geometry and instruction width.
package mips_pkg;

    localparam int          INSTR_W      = 32;
    localparam int          IM_AW_DEF    = 10;
    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifu_pc.sv
// PC register with next-PC selection (pc+4 / redirect target / hold) and a sticky misalignment fault.
// One-edge update; redirect_i wins over advance_i, and a misaligned target leaves the PC untouched.
module ifu_pc
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic        fault_o,
    output logic        misalign_o
);

    logic [31:0] pc_q, pc_d;
    logic        fault_q, fault_d;

    assign misalign_o = (redirect_pc_i[1:0] != 2'b00);

    always_comb begin
        pc_d    = pc_q;
        fault_d = fault_q;
        if (redirect_i) begin
            if (misalign_o) begin
                fault_d = 1'b1;
            end else begin
                pc_d = redirect_pc_i;
            end
        end else if (advance_i) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= PC_RESET;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    assign pc_o    = pc_q;
    assign fault_o = fault_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: drives IM from the PC, latches IR/PC and offers them on a valid/ready handshake.
// One edge from PC to ir_valid; IR held stable while ir_ready is low, one instruction per cycle otherwise.
module ifu
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter int          IM_AW    = IM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IM_AW-1:0]   im_addr,
    input  logic [INSTR_W-1:0] im_dout,
    output logic [INSTR_W-1:0] ir,
    output logic [31:0]        ir_pc,
    output logic [31:0]        ir_pc4,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               fault,
    output logic [31:0]        fetch_cnt
);

    fetch_state_e       state_q;
    logic [INSTR_W-1:0] ir_q;
    logic [31:0]        ir_pc_q, ir_pc4_q, fetch_cnt_q;
    logic               ir_valid_q;

    logic [31:0] pc;
    logic        misalign;
    logic        redir_eff, handshake, capture;

    // A halted unit ignores redirects entirely; only reset leaves S_HALT.
    assign redir_eff = redirect && (state_q != S_HALT);
    assign handshake = !redir_eff && (state_q == S_HOLD) && ir_valid_q && ir_ready;
    assign capture   = !redir_eff && ((state_q == S_FETCH) || handshake);

    ifu_pc #(
        .PC_RESET (PC_RESET)
    ) u_pc (
        .clk           (clk),
        .rst_n         (rst_n),
        .advance_i     (capture),
        .redirect_i    (redir_eff),
        .redirect_pc_i (redirect_pc),
        .pc_o          (pc),
        .fault_o       (fault),
        .misalign_o    (misalign)
    );

    assign im_addr = pc[IM_AW+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RST;
            ir_q        <= '0;
            ir_pc_q     <= '0;
            ir_pc4_q    <= '0;
            ir_valid_q  <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            if (handshake) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (redir_eff) begin
                ir_valid_q <= 1'b0;
                state_q    <= misalign ? S_HALT : S_FETCH;
            end else begin
                case (state_q)
                    S_RST: state_q <= S_FETCH;
                    S_FETCH, S_HOLD: begin
                        if (capture) begin
                            ir_q       <= im_dout;
                            ir_pc_q    <= pc;
                            ir_pc4_q   <= pc + 32'd4;
                            ir_valid_q <= 1'b1;
                            state_q    <= S_HOLD;
                        end
                    end
                    default: ir_valid_q <= 1'b0;
                endcase
            end
        end
    end

    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_pc4    = ir_pc4_q;
    assign ir_valid  = ir_valid_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
- Instruction fetch unit for the multicycle MIPS datapath.
- Holds the PC and drives the word address into the instruction memory, whose read is combinational.
- Latches the returned instruction into the instruction register (IR) and hands IR/PC to the decode/control stage over a valid/ready handshake.
- Accepts redirects (branch/jump target) from the downstream stages.

Parameters:
- PC_RESET, 32'h0000_3000: PC value after reset; must be word-aligned.
- IM_AW, 10: instruction memory word-address width; the IM indexes pc[IM_AW+1:2].

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- im_addr  out  IM_AW  word address to IM; combinationally equals pc[IM_AW+1:2]
- im_dout  in  32  instruction word returned by IM, valid in the same cycle as im_addr
- ir  out  32  latched instruction
- ir_pc  out  32  address of the instruction in ir
- ir_pc4  out  32  ir_pc + 4, for link/branch arithmetic
- ir_valid  out  1  ir/ir_pc/ir_pc4 hold an unconsumed instruction
- ir_ready  in  1  consumer accepts the instruction this cycle
- redirect  in  1  load redirect_pc into the PC, flush IR
- redirect_pc  in  32  redirect target
- fault  out  1  sticky: misaligned redirect target seen
- fetch_cnt  out  32  count of completed handshakes, wraps modulo 2^32

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately even mid-operation):
  - pc=PC_RESET, ir=0, ir_pc=0, ir_pc4=0, ir_valid=0, fault=0, fetch_cnt=0, state=S_RST.
- States: S_RST, S_FETCH, S_HOLD, S_HALT.
- S_RST:
  - No capture; the IM address settles.
  - Next cycle goes to S_FETCH, unless redirect is asserted (see redirect rule).
- S_FETCH, at the clock edge:
  - ir<=im_dout, ir_pc<=pc, ir_pc4<=pc+4, pc<=pc+4, ir_valid<=1, go to S_HOLD.
  - Latency: one edge from PC to ir_valid=1.
- S_HOLD:
  - ir, ir_pc, ir_pc4 and ir_valid=1 stay stable while ir_ready=0.
  - On ir_valid&&ir_ready: fetch_cnt<=fetch_cnt+1, and the next instruction is captured at the same edge (same updates as S_FETCH); remain in S_HOLD.
  - Throughput: one instruction per cycle if ir_ready is held high.
- Redirect has priority over everything except reset, in any state other than S_HALT:
  - pc<=redirect_pc, ir_valid<=0, state<=S_FETCH.
  - A held instruction is discarded. An ir_ready in the same cycle is ignored: no fetch_cnt increment, no capture.
  - If redirect_pc[1:0]!=0: fault<=1, pc unchanged, ir_valid<=0, state<=S_HALT.
- S_HALT:
  - ir_valid=0; redirect and ir_ready are ignored.
  - Exit only by reset.
- Arithmetic:
  - pc+4 wraps modulo 2^32.
  - im_addr uses only pc[IM_AW+1:2], so the fetch wraps at 4 KiB. pc[31:IM_AW+2] is ignored by the IM; PC_RESET 0x3000 maps to index 0.
- ir_ready while ir_valid=0: no effect.
- im_addr is always driven from pc, including in S_HALT.

Decomposition:
- Shared package mips_pkg:
  - fetch state encoding (S_RST=2'd0, S_FETCH=2'd1, S_HOLD=2'd2, S_HALT=2'd3);
  - PC_RESET default;
  - IM_AW;
  - instruction width constant 32.
- One natural sub-module, ifu_pc:
  - PC register and next-PC mux (pc+4 / redirect_pc / hold);
  - alignment check;
  - sticky fault flag.
- ifu keeps the FSM, IR/IR_PC registers, handshake logic and fetch_cnt.

Test Plan:
- Reset, IM preloaded with word i = 32'h1000_0000+i, ir_ready=1:
  - im_addr=0 during S_RST;
  - ir_valid rises one edge after S_FETCH with ir=32'h1000_0000, ir_pc=0x3000, ir_pc4=0x3004;
  - then one new instruction per cycle;
  - fetch_cnt=8 after 8 handshakes.
- Backpressure, ir_ready=0 for 5 cycles after the first capture:
  - ir, ir_pc, ir_valid stable;
  - pc=0x3004, im_addr=1;
  - raising ir_ready consumes word 0 and captures word 1 at the same edge.
- Redirect to 0x3040 together with ir_ready=1 while holding ir_pc=0x3008:
  - next cycle ir_valid=0 and fetch_cnt unchanged;
  - one edge later ir_pc=0x3040, ir=word 16.
- Redirect to 0x3042:
  - fault=1, ir_valid=0 permanently, pc unchanged;
  - later redirects and ir_ready are ignored until rst_n low.
- Wrap, redirect to 0x3FFC:
  - captures word 1023;
  - next fetch has ir_pc=0x4000, im_addr=0 (word 0);
  - separately, redirect to 0xFFFF_FFFC gives next pc 0x0000_0000.
- rst_n asserted asynchronously mid-S_HOLD, between clock edges:
  - ir_valid=0, fault=0, fetch_cnt=0, pc=PC_RESET without waiting for a clock edge;
  - on release, the sequence restarts from S_RST.
